// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: fetches a PTE on a lookup miss and installs it into the
// fully associative CAM (first invalid line, else round-robin), or flags a page fault.
module tlb_refill_ctrl #(
    parameter int ENTRIES = 8,
    parameter int AW      = 3,
    parameter int VPNW    = 20
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            lookup_valid,
    input  logic [VPNW-1:0] vpn,
    input  logic            hit,
    input  logic [31:0]     ptbr,
    output logic            busy,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            cam_wren,
    output logic [AW-1:0]   cam_wraddress,
    output logic [VPNW-1:0] cam_pattern,
    output logic [19:0]     pfn_wdata,
    output logic            refill_done,
    output logic            page_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, FAULT} state_t;

    state_t            state;
    logic [VPNW-1:0]   vpn_r;
    logic [31:0]       pte_r;
    logic [ENTRIES-1:0] valid_sh;
    logic [AW-1:0]     rr_ptr;
    logic [AW-1:0]     victim;
    logic              pte_flags_unused;

    // Lowest-index invalid line wins; only a full CAM falls back to the round-robin pointer.
    function automatic logic [AW-1:0] pick_victim(input logic [ENTRIES-1:0] valid,
                                                  input logic [AW-1:0]      rr);
        logic [AW-1:0] idx;
        idx = rr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    assign victim = pick_victim(valid_sh, rr_ptr);

    // Data-side write fields are decoded from held registers, so they are zero outside WRITE.
    assign cam_pattern      = (state == WRITE) ? vpn_r : '0;
    assign pfn_wdata        = (state == WRITE) ? pte_r[31:12] : '0;
    assign pte_flags_unused = ^pte_r[11:0];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state         <= IDLE;
            vpn_r         <= '0;
            pte_r         <= '0;
            valid_sh      <= '0;
            rr_ptr        <= '0;
            busy          <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            cam_wren      <= 1'b0;
            cam_wraddress <= '0;
            refill_done   <= 1'b0;
            page_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lookup_valid && !hit) begin
                        vpn_r    <= vpn;
                        mem_addr <= ptbr + 32'({vpn, 2'b00});
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        pte_r    <= mem_rdata;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                        if (mem_rdata[0]) begin
                            state            <= WRITE;
                            cam_wren         <= 1'b1;
                            cam_wraddress    <= victim;
                            refill_done      <= 1'b1;
                            valid_sh[victim] <= 1'b1;
                            if (&valid_sh) rr_ptr <= rr_ptr + AW'(1);
                        end else begin
                            state      <= FAULT;
                            page_fault <= 1'b1;
                        end
                    end
                end
                WRITE, FAULT: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cam_wren      <= 1'b0;
                    cam_wraddress <= '0;
                    refill_done   <= 1'b0;
                    page_fault    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Scoreboard bench for tlb_refill_ctrl: stimulus pushes expected PTE addresses and
// install/fault events from a reference model; a monitor pops and compares them.
module tb_tlb_refill_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        lookup_valid;
    logic [19:0] vpn;
    logic        hit;
    logic [31:0] ptbr;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cam_wren;
    logic [2:0]  cam_wraddress;
    logic [19:0] cam_pattern;
    logic [19:0] pfn_wdata;
    logic        refill_done;
    logic        page_fault;

    always #5 clk = ~clk;

    tlb_refill_ctrl #(.ENTRIES(8), .AW(3), .VPNW(20)) dut (
        .clk(clk), .clrn(clrn), .lookup_valid(lookup_valid), .vpn(vpn), .hit(hit),
        .ptbr(ptbr), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cam_wren(cam_wren),
        .cam_wraddress(cam_wraddress), .cam_pattern(cam_pattern), .pfn_wdata(pfn_wdata),
        .refill_done(refill_done), .page_fault(page_fault)
    );

    typedef struct packed {
        logic        fault;
        logic [2:0]  line;
        logic [19:0] vpn;
        logic [19:0] pfn;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference model of the CAM occupancy
    bit m_valid[8];
    int m_rr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic model_install(input logic [19:0] v, input logic [31:0] pte);
        exp_t e;
        int   vic;
        bit   full;
        e = '0;
        if (pte[0]) begin
            vic  = -1;
            full = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (!m_valid[i] && vic < 0) vic = i;
                if (!m_valid[i]) full = 1'b0;
            end
            if (full) begin
                vic  = m_rr;
                m_rr = (m_rr + 1) % 8;
            end
            m_valid[vic] = 1'b1;
            e.line = 3'(vic);
            e.vpn  = v;
            e.pfn  = pte[31:12];
        end else begin
            e.fault = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare each presented request / install / fault against the queues
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_req === 1'b1 && req_prev !== 1'b1) begin
            if (addr_q.size() == 0) check("unexpected_mem_req", 1, 0);
            else check("mem_addr", mem_addr, addr_q.pop_front());
        end
        req_prev <= mem_req;
        if (cam_wren === 1'b1 || page_fault === 1'b1 || refill_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("page_fault", page_fault, e.fault);
                check("cam_wren", cam_wren, !e.fault);
                check("refill_done", refill_done, !e.fault);
                if (!e.fault) begin
                    check("cam_wraddress", cam_wraddress, e.line);
                    check("cam_pattern", cam_pattern, e.vpn);
                    check("pfn_wdata", pfn_wdata, e.pfn);
                end else begin
                    check("fault_data_zero", {cam_wraddress, cam_pattern, pfn_wdata}, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        clrn         = 1'b0;
        lookup_valid = 1'b0;
        hit          = 1'b0;
        mem_ack      = 1'b0;
        repeat (cycles) tick();
        clrn = 1'b1;
        model_clear();
    endtask

    task automatic do_miss(input logic [19:0] v, input logic [31:0] pte, input int delay);
        lookup_valid = 1'b1;
        hit          = 1'b0;
        vpn          = v;
        addr_q.push_back(ptbr + 32'({v, 2'b00}));
        tick();
        lookup_valid = 1'b0;
        check("busy_after_miss", busy, 1);
        check("mem_req_latency", mem_req, 1);
        // Lookups presented while busy must be ignored
        repeat (delay) begin
            lookup_valid = 1'($urandom_range(0, 1));
            hit          = 1'($urandom_range(0, 1));
            vpn          = 20'($urandom);
            tick();
        end
        lookup_valid = 1'b0;
        hit          = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = pte;
        model_install(v, pte);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("busy_in_finish", busy, 1);
        tick();
        check("busy_clear", busy, 0);
        check("mem_req_clear", mem_req, 0);
    endtask

    initial begin
        clrn         = 1'b0;
        lookup_valid = 1'b0;
        vpn          = '0;
        hit          = 1'b0;
        ptbr         = 32'h0010_0000;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        model_clear();

        do_reset(2);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_cam_wren", cam_wren, 0);
        check("rst_refill_done", refill_done, 0);
        check("rst_page_fault", page_fault, 0);
        check("rst_data_zero", {mem_addr, cam_wraddress, cam_pattern, pfn_wdata}, 0);

        // Directed miss: address 0x0014_8D14, install into line 0
        do_miss(20'h12345, 32'hABCD_E001, 1);

        // Fill eight lines, then wrap round-robin twice
        do_reset(2);
        for (int i = 0; i < 10; i++)
            do_miss(20'(32'h100 + i * 7), {20'($urandom), 11'($urandom), 1'b1}, i % 3);

        // Fault leaves the CAM untouched; the next install still uses line 0
        do_reset(2);
        do_miss(20'h0ABCD, 32'h0000_0000, 2);
        do_miss(20'h0BCDE, 32'h1234_5001, 0);

        // Reset while the request is outstanding; a late ack must be ignored
        lookup_valid = 1'b1;
        vpn          = 20'h77777;
        addr_q.push_back(ptbr + 32'({20'h77777, 2'b00}));
        tick();
        lookup_valid = 1'b0;
        check("req_before_reset", mem_req, 1);
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        model_clear();
        check("req_dropped", mem_req, 0);
        check("busy_dropped", busy, 0);
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_F001;
        tick();
        mem_ack = 1'b0;
        check("late_ack_no_wren", cam_wren, 0);
        check("late_ack_busy", busy, 0);
        do_miss(20'h00042, 32'h0004_2001, 1);

        // Hits never start a refill
        repeat (3) begin
            lookup_valid = 1'b1;
            hit          = 1'b1;
            vpn          = 20'($urandom);
            tick();
            check("hit_no_req", mem_req, 0);
            check("hit_not_busy", busy, 0);
        end
        lookup_valid = 1'b0;
        hit          = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            ptbr = $urandom & 32'hFFFF_F000;
            if ($urandom_range(0, 3) == 0) begin
                lookup_valid = 1'b1;
                hit          = 1'b1;
                vpn          = 20'($urandom);
                tick();
                lookup_valid = 1'b0;
                hit          = 1'b0;
            end else begin
                do_miss(20'($urandom), {20'($urandom), 11'($urandom),
                        1'($urandom_range(0, 3) != 0)}, $urandom_range(0, 3));
            end
        end

        tick();
        tick();
        check("exp_q_drained", 64'(exp_q.size()), 0);
        check("addr_q_drained", 64'(addr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
